// File: rtl/inverse_diffusion_layer_pkg.sv
// Shared types, rotation constants and helpers for the inverse Ascon diffusion layer.
// Works with or without the INV_DIFF_CHECK_EN self-check build option.
package inverse_diffusion_layer_pkg;

    localparam int unsigned NUM_WORDS  = 5;
    localparam int unsigned WORD_W     = 64;
    localparam int unsigned NUM_STAGES = 6;
    localparam int unsigned STEP_W     = 3;

    typedef logic [NUM_WORDS-1:0][WORD_W-1:0] type_state;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } fsm_state_e;

    localparam int unsigned ROT_A [NUM_WORDS] = '{19, 61, 1, 10, 7};
    localparam int unsigned ROT_B [NUM_WORDS] = '{28, 39, 6, 17, 41};

    // Rotation of stage k is 2^k times the base amount, reduced mod 64.
    function automatic int unsigned stage_rot(input int unsigned amt, input int unsigned k);
        return (amt << k) % WORD_W;
    endfunction

    function automatic logic [WORD_W-1:0] ror64(input logic [WORD_W-1:0] x, input logic [5:0] n);
        return (x >> n) | (x << (7'd64 - {1'b0, n}));
    endfunction

    // Forward linear layer, used to re-derive the input from a finished result.
    function automatic type_state diffuse(input type_state s);
        type_state r;
        for (int w = 0; w < int'(NUM_WORDS); w++) begin
            r[w] = s[w] ^ ror64(s[w], 6'(ROT_A[w])) ^ ror64(s[w], 6'(ROT_B[w]));
        end
        return r;
    endfunction

endpackage

// File: rtl/inverse_diffusion_layer_stage.sv
// One factor L_K of the inverse diffusion product, applied to all five words.
// Purely combinational; K selects the power-of-two scaled rotation amounts.
module inv_diffusion_stage
    import inverse_diffusion_layer_pkg::*;
#(
    parameter int unsigned K = 0
) (
    input  type_state state_i,
    output type_state state_o
);

    if (K >= NUM_STAGES) begin : g_bad_k
        $error("inv_diffusion_stage: K must be 0..5");
    end

    for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
        localparam logic [5:0] RA = 6'(stage_rot(ROT_A[w], K));
        localparam logic [5:0] RB = 6'(stage_rot(ROT_B[w], K));
        assign state_o[w] = state_i[w] ^ ror64(state_i[w], RA) ^ ror64(state_i[w], RB);
    end

endmodule

// File: rtl/inverse_diffusion_layer.sv
// Sequential inverse of the Ascon diffusion layer: L^-1 = L_0*L_1*...*L_5, UNROLL stages per clock.
// Define INV_DIFF_CHECK_EN to add a one-cycle forward re-check that drives error_o.
module inverse_diffusion_layer
    import inverse_diffusion_layer_pkg::*;
#(
    parameter int unsigned UNROLL = 1
) (
    input  logic      clock_i,
    input  logic      resetb_i,
    input  logic      valid_i,
    output logic      ready_o,
    input  type_state inv_diffusion_i,
    output logic      valid_o,
    input  logic      ready_i,
    output type_state inv_diffusion_o,
    output logic      error_o
);

    localparam int unsigned NGRP = NUM_STAGES / UNROLL;

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 || UNROLL == 6)) begin : g_bad_unroll
        $error("inverse_diffusion_layer: UNROLL must be 1, 2, 3 or 6");
    end

`ifdef INV_DIFF_CHECK_EN
    localparam fsm_state_e AFTER_RUN = ST_CHECK;
`else
    localparam fsm_state_e AFTER_RUN = ST_DONE;
`endif

    fsm_state_e        state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    type_state         work_q, work_d;
    logic              valid_q, valid_d;
    logic              ready_q, ready_d;
    type_state         run_res;
    type_state         chain [NGRP][UNROLL+1];

    // Group g holds the chain of stages K = g*UNROLL .. g*UNROLL+UNROLL-1.
    for (genvar g = 0; g < NGRP; g++) begin : g_grp
        assign chain[g][0] = work_q;
        for (genvar j = 0; j < UNROLL; j++) begin : g_stg
            inv_diffusion_stage #(
                .K(g * UNROLL + j)
            ) u_stage (
                .state_i(chain[g][j]),
                .state_o(chain[g][j+1])
            );
        end
    end

    always_comb begin
        run_res = work_q;
        for (int g = 0; g < int'(NGRP); g++) begin
            if (step_q == STEP_W'(g * int'(UNROLL))) begin
                run_res = chain[g][UNROLL];
            end
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (valid_i) state_d = ST_RUN;
            ST_RUN:   if (step_q + STEP_W'(UNROLL) == STEP_W'(NUM_STAGES)) state_d = AFTER_RUN;
            ST_CHECK: state_d = ST_DONE;
            ST_DONE:  if (ready_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

`ifdef INV_DIFF_CHECK_EN
    type_state shadow_q, shadow_d;
    logic      err_q, err_d;
`endif

    // Handshake flags are registered from the next state so they align with state_q.
    always_comb begin
        step_d  = step_q;
        work_d  = work_q;
        valid_d = (state_d == ST_DONE);
        ready_d = (state_d == ST_IDLE);
`ifdef INV_DIFF_CHECK_EN
        shadow_d = shadow_q;
        err_d    = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    work_d = inv_diffusion_i;
                    step_d = '0;
`ifdef INV_DIFF_CHECK_EN
                    shadow_d = inv_diffusion_i;
                    err_d    = 1'b0;
`endif
                end
            end
            ST_RUN: begin
                work_d = run_res;
                step_d = step_q + STEP_W'(UNROLL);
            end
            ST_CHECK: begin
`ifdef INV_DIFF_CHECK_EN
                err_d = (diffuse(work_q) != shadow_q);
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            step_q  <= '0;
            work_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            step_q  <= step_d;
            work_q  <= work_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

`ifdef INV_DIFF_CHECK_EN
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            shadow_q <= '0;
            err_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            err_q    <= err_d;
        end
    end
    assign error_o = err_q;
`else
    assign error_o = 1'b0;
`endif

    assign ready_o         = ready_q;
    assign valid_o         = valid_q;
    assign inv_diffusion_o = work_q;

endmodule

// File: tb/tb_inverse_diffusion_layer.sv
// Directed bench for inverse_diffusion_layer; one instance per legal UNROLL value.
// Expected results come from hand-given states and a bench-local forward layer.
module tb_inverse_diffusion_layer;
    import inverse_diffusion_layer_pkg::*;

`ifdef INV_DIFF_CHECK_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif
    localparam int UR [4] = '{1, 2, 3, 6};

    logic      clk;
    logic      rstb;
    logic      vi   [4];
    logic      ro   [4];
    logic      vo   [4];
    logic      ri   [4];
    logic      eo   [4];
    type_state di   [4];
    type_state dout [4];

    int n_tests;
    int n_fail;

    for (genvar i = 0; i < 4; i++) begin : g_dut
        inverse_diffusion_layer #(
            .UNROLL(UR[i])
        ) u_dut (
            .clock_i        (clk),
            .resetb_i       (rstb),
            .valid_i        (vi[i]),
            .ready_o        (ro[i]),
            .inv_diffusion_i(di[i]),
            .valid_o        (vo[i]),
            .ready_i        (ri[i]),
            .inv_diffusion_o(dout[i]),
            .error_o        (eo[i])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] rr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Forward Ascon linear layer, written independently of the design package.
    function automatic type_state fwd(input type_state s);
        int ra [5];
        int rb [5];
        type_state r;
        ra = '{19, 61, 1, 10, 7};
        rb = '{28, 39, 6, 17, 41};
        for (int w = 0; w < 5; w++) r[w] = s[w] ^ rr(s[w], ra[w]) ^ rr(s[w], rb[w]);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one state, then wait (bounded) for valid_o; lat counts edges including the accept edge.
    task automatic transact(input int idx, input type_state s, output int lat, output type_state res);
        di[idx] = s;
        vi[idx] = 1'b1;
        ri[idx] = 1'b0;
        tick();
        vi[idx] = 1'b0;
        lat = 1;
        while (vo[idx] !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        res = dout[idx];
    endtask

    task automatic handshake(input int idx);
        ri[idx] = 1'b1;
        tick();
        ri[idx] = 1'b0;
    endtask

    task automatic test_reset();
        rstb = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vi[i] = 1'b0;
            ri[i] = 1'b0;
            di[i] = '0;
        end
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (ro[i] !== 1'b1 || vo[i] !== 1'b0 || dout[i] !== '0 || eo[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset[%0d]: ready=%b valid=%b err=%b out=%h, required 1 0 0 zero",
                         i, ro[i], vo[i], eo[i], dout[i]);
            end
        end
        rstb = 1'b1;
        tick();
    endtask

    task automatic test_zero();
        int lat;
        type_state res;
        transact(0, '0, lat, res);
        n_tests++;
        if (vo[0] !== 1'b1 || lat !== 7 + CHK) begin
            n_fail++;
            $display("FAIL zero_latency: valid=%b lat=%0d, required 1 lat=%0d", vo[0], lat, 7 + CHK);
        end
        n_tests++;
        if (res !== '0 || eo[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_value: out=%h err=%b, required zero err=0", res, eo[0]);
        end
        handshake(0);
        n_tests++;
        if (vo[0] !== 1'b0 || ro[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_release: valid=%b ready=%b, required 0 1", vo[0], ro[0]);
        end
    endtask

    task automatic test_round_trip();
        int lat;
        type_state x;
        type_state res;
        x = {64'h8859263f4c5d6e8f, 64'h00c18e8584858607, 64'h7f7f7f7f7f7f7f8f,
             64'h80c0848680808070, 64'h8888888a88888888};
        transact(0, fwd(x), lat, res);
        n_tests++;
        if (res !== x || lat !== 7 + CHK || eo[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL round_trip: out=%h lat=%0d err=%b, required %h lat=%0d err=0",
                     res, lat, eo[0], x, 7 + CHK);
        end
        handshake(0);
    endtask

    task automatic test_all_ones();
        int lat;
        type_state s;
        type_state res;
        s = '0;
        s[2] = 64'hffffffffffffffff;
        for (int i = 0; i < 4; i++) begin
            transact(i, s, lat, res);
            n_tests++;
            if (res !== s || lat !== 6 / UR[i] + 1 + CHK) begin
                n_fail++;
                $display("FAIL all_ones[u=%0d]: out=%h lat=%0d, required %h lat=%0d",
                         UR[i], res, lat, s, 6 / UR[i] + 1 + CHK);
            end
            handshake(i);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        type_state x2;
        type_state x3;
        type_state res;
        x2 = {64'h0123456789abcdef, 64'hfedcba9876543210, 64'hdeadbeefcafef00d,
              64'h0000000000000000, 64'h5555aaaa5555aaaa};
        x3 = {64'h0000000000000001, 64'h8000000000000000, 64'hffff0000ffff0000,
              64'h13579bdf2468ace0, 64'h0f0f0f0f0f0f0f0f};
        transact(0, fwd(x2), lat, res);
        n_tests++;
        if (res !== x2) begin
            n_fail++;
            $display("FAIL bp_first: out=%h, required %h", res, x2);
        end
        di[0] = fwd(x3);
        vi[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_tests++;
            if (vo[0] !== 1'b1 || ro[0] !== 1'b0 || dout[0] !== x2) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: valid=%b ready=%b out=%h, required 1 0 %h",
                         c, vo[0], ro[0], dout[0], x2);
            end
        end
        ri[0] = 1'b1;
        tick();
        ri[0] = 1'b0;
        n_tests++;
        if (vo[0] !== 1'b0 || ro[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: valid=%b ready=%b, required 0 1", vo[0], ro[0]);
        end
        tick();
        vi[0] = 1'b0;
        n_tests++;
        if (ro[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_accept2: ready=%b, required 0", ro[0]);
        end
        lat = 1;
        while (vo[0] !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        n_tests++;
        if (dout[0] !== x3 || lat !== 7 + CHK) begin
            n_fail++;
            $display("FAIL bp_second: out=%h lat=%0d, required %h lat=%0d", dout[0], lat, x3, 7 + CHK);
        end
        handshake(0);
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        di[0] = fwd({64'h1, 64'h2, 64'h3, 64'h4, 64'h5});
        vi[0] = 1'b1;
        tick();
        vi[0] = 1'b0;
        tick();
        tick();
        tick();
        rstb = 1'b0;
        #1;
        n_tests++;
        if (vo[0] !== 1'b0 || ro[0] !== 1'b1 || dout[0] !== '0 || eo[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: valid=%b ready=%b err=%b out=%h, required 0 1 0 zero",
                     vo[0], ro[0], eo[0], dout[0]);
        end
        tick();
        rstb = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (vo[0] === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0 || ro[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_no_output: valid_seen=%b ready=%b, required 0 1", seen, ro[0]);
        end
    endtask

`ifdef INV_DIFF_CHECK_EN
    task automatic test_check_error();
        type_state x;
        x = {64'hcafebabe00000000, 64'h1, 64'h2, 64'h3, 64'h4};
        di[0] = fwd(x);
        vi[0] = 1'b1;
        tick();
        vi[0] = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        force g_dut[0].u_dut.work_q = ~x;
        tick();
        n_tests++;
        if (vo[0] !== 1'b1 || eo[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL check_error: valid=%b err=%b, required 1 1", vo[0], eo[0]);
        end
        release g_dut[0].u_dut.work_q;
        handshake(0);
    endtask
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_zero();
        test_round_trip();
        test_all_ones();
        test_backpressure();
        test_reset_mid_run();
`ifdef INV_DIFF_CHECK_EN
        test_check_error();
        test_round_trip();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
